// File: rtl/hilo_acc_unit.sv
// HI/LO register pair for the multiply datapath: load, accumulate (optionally split
// into a low-half and a high-half cycle), direct writes and clear.
//
// state  | meaning
// IDLE   | ready for a new op; Hi/Lo coherent
// ACC_LO | captured product being added to / subtracted from Lo
// ACC_HI | high half plus carry/borrow being applied to Hi
module hilo_acc_unit #(
  parameter int W         = 32,
  parameter bit SPLIT_ACC = 1'b1
) (
  input  logic           Clk,
  input  logic           Reset,
  input  logic           OpValid,
  input  logic [2:0]     OpCode,
  input  logic [2*W-1:0] Product,
  input  logic [W-1:0]   WrData,
  output logic           OpReady,
  output logic           Busy,
  output logic           Done,
  output logic [W-1:0]   Hi,
  output logic [W-1:0]   Lo
);

  typedef enum logic [1:0] {IDLE, ACC_LO, ACC_HI} state_t;

  localparam logic [2:0] OP_LOAD = 3'd1;
  localparam logic [2:0] OP_MADD = 3'd2;
  localparam logic [2:0] OP_MSUB = 3'd3;
  localparam logic [2:0] OP_MTHI = 3'd4;
  localparam logic [2:0] OP_MTLO = 3'd5;
  localparam logic [2:0] OP_CLR  = 3'd6;

  state_t         state;
  logic [2*W-1:0] prod_q;
  logic           sub_q;
  logic           cy_q;
  logic           accept;
  logic [W:0]     lo_sum;
  logic [W-1:0]   hi_sum;
  logic [2*W-1:0] full_sum;

  assign Busy    = (state != IDLE);
  assign OpReady = ~Busy;
  assign accept  = OpValid & (state == IDLE);

  // Top bit of the widened low-half result is the carry (add) or borrow (sub).
  always_comb begin
    lo_sum = '0;
    hi_sum = '0;
    if (sub_q) begin
      lo_sum = {1'b0, Lo} - {1'b0, prod_q[W-1:0]};
      hi_sum = Hi - prod_q[2*W-1:W] - {{(W-1){1'b0}}, cy_q};
    end else begin
      lo_sum = {1'b0, Lo} + {1'b0, prod_q[W-1:0]};
      hi_sum = Hi + prod_q[2*W-1:W] + {{(W-1){1'b0}}, cy_q};
    end
  end

  always_comb begin
    full_sum = '0;
    if (OpCode == OP_MSUB) full_sum = {Hi, Lo} - Product;
    else                   full_sum = {Hi, Lo} + Product;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state  <= IDLE;
      Hi     <= '0;
      Lo     <= '0;
      prod_q <= '0;
      sub_q  <= 1'b0;
      cy_q   <= 1'b0;
      Done   <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            case (OpCode)
              OP_LOAD: begin
                Hi   <= Product[2*W-1:W];
                Lo   <= Product[W-1:0];
                Done <= 1'b1;
              end
              OP_MADD, OP_MSUB: begin
                if (SPLIT_ACC) begin
                  prod_q <= Product;
                  sub_q  <= (OpCode == OP_MSUB);
                  state  <= ACC_LO;
                end else begin
                  Hi   <= full_sum[2*W-1:W];
                  Lo   <= full_sum[W-1:0];
                  Done <= 1'b1;
                end
              end
              OP_MTHI: begin
                Hi   <= WrData;
                Done <= 1'b1;
              end
              OP_MTLO: begin
                Lo   <= WrData;
                Done <= 1'b1;
              end
              OP_CLR: begin
                Hi   <= '0;
                Lo   <= '0;
                Done <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        ACC_LO: begin
          Lo    <= lo_sum[W-1:0];
          cy_q  <= lo_sum[W];
          state <= ACC_HI;
        end
        ACC_HI: begin
          Hi    <= hi_sum;
          state <= IDLE;
          Done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_acc_unit.sv
// Scoreboard bench for hilo_acc_unit: split-accumulate and single-cycle instances
// driven from the same lines, expected Hi:Lo pushed at issue, popped on Done.
module tb_hilo_acc_unit;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        OpValid = 1'b0;
  logic [2:0]  OpCode = 3'd0;
  logic [63:0] Product = '0;
  logic [31:0] WrData = '0;
  logic        en0 = 1'b1;
  logic        ov0;

  logic        OpReady, Busy, Done;
  logic [31:0] Hi, Lo;
  logic        OpReady0, Busy0, Done0;
  logic [31:0] Hi0, Lo0;

  int checks = 0;
  int errors = 0;
  logic [63:0] q1[$];
  logic [63:0] q0[$];

  assign ov0 = OpValid & en0;

  always #5 Clk = ~Clk;

  hilo_acc_unit #(.W(32), .SPLIT_ACC(1'b1)) dut (
    .Clk(Clk), .Reset(Reset), .OpValid(OpValid), .OpCode(OpCode), .Product(Product),
    .WrData(WrData), .OpReady(OpReady), .Busy(Busy), .Done(Done), .Hi(Hi), .Lo(Lo));

  hilo_acc_unit #(.W(32), .SPLIT_ACC(1'b0)) dut0 (
    .Clk(Clk), .Reset(Reset), .OpValid(ov0), .OpCode(OpCode), .Product(Product),
    .WrData(WrData), .OpReady(OpReady0), .Busy(Busy0), .Done(Done0), .Hi(Hi0), .Lo(Lo0));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  // Monitors: pop the expected Hi:Lo whenever a Done pulse is seen.
  always @(negedge Clk) begin
    if (Done === 1'b1) begin
      chk("split done_not_busy", {63'd0, Busy}, 64'd0);
      if (q1.size() == 0) chk("split unexpected_done", 64'd1, 64'd0);
      else chk("split hilo", {Hi, Lo}, q1.pop_front());
    end
  end

  always @(negedge Clk) begin
    if (Done0 === 1'b1) begin
      if (q0.size() == 0) chk("single unexpected_done", 64'd1, 64'd0);
      else chk("single hilo", {Hi0, Lo0}, q0.pop_front());
    end
  end

  // One-cycle request; product is scrambled afterwards to prove it was captured.
  task automatic issue(input logic [2:0] op, input logic [63:0] p, input logic [31:0] wd,
                       input bit push, input logic [63:0] exp);
    @(negedge Clk);
    OpValid = 1'b1; OpCode = op; Product = p; WrData = wd;
    if (push) begin
      q1.push_back(exp);
      if (en0) q0.push_back(exp);
    end
    @(negedge Clk);
    OpValid = 1'b0;
    Product = {$urandom(), $urandom()};
  endtask

  task automatic wait_idle();
    int n = 0;
    while (Busy === 1'b1 && n < 20) begin
      @(negedge Clk);
      n++;
    end
    if (Busy === 1'b1) chk("wait_idle timeout", 64'd1, 64'd0);
  endtask

  initial begin
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    chk("reset hilo", {Hi, Lo}, 64'd0);
    chk("reset busy/ready/done", {61'd0, Busy, OpReady, Done}, 64'b010);

    // LOAD: single-cycle, never busy
    issue(3'd1, 64'h00000001_FFFFFFFF, 32'd0, 1'b1, 64'h00000001_FFFFFFFF);
    chk("load busy", {63'd0, Busy}, 64'd0);

    // MADD P=1 with carry out of Lo; check intermediate states
    issue(3'd2, 64'd1, 32'd0, 1'b1, 64'h00000002_00000000);
    chk("madd k busy/ready", {62'd0, Busy, OpReady}, 64'b10);
    @(negedge Clk);
    chk("madd k+1 hilo", {Hi, Lo}, 64'h00000001_00000000);
    chk("madd k+1 busy", {63'd0, Busy}, 64'd1);
    @(negedge Clk);
    chk("madd k+2 busy/ready", {62'd0, Busy, OpReady}, 64'b01);

    // CLR, MSUB borrow wrap, MADD carry ripple
    issue(3'd6, 64'd0, 32'd0, 1'b1, 64'd0);
    issue(3'd3, 64'd1, 32'd0, 1'b1, 64'hFFFFFFFF_FFFFFFFF);
    wait_idle();
    issue(3'd2, 64'd1, 32'd0, 1'b1, 64'd0);
    wait_idle();

    // MSUB with high half and borrow: 5:3 - 1:4 = 3:FFFFFFFF
    issue(3'd1, 64'h00000005_00000003, 32'd0, 1'b1, 64'h00000005_00000003);
    issue(3'd3, 64'h00000001_00000004, 32'd0, 1'b1, 64'h00000003_FFFFFFFF);
    wait_idle();
    issue(3'd4, 64'd0, 32'h0000DEAD, 1'b1, 64'h0000DEAD_FFFFFFFF);
    issue(3'd5, 64'd0, 32'h00001234, 1'b1, 64'h0000DEAD_00001234);

    // NOP and reserved: no state change, no Done
    issue(3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFFFFFF, 1'b0, 64'd0);
    chk("nop done", {63'd0, Done}, 64'd0);
    issue(3'd7, 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFFFFFF, 1'b0, 64'd0);
    chk("rsvd done", {63'd0, Done}, 64'd0);
    chk("rsvd hilo", {Hi, Lo}, 64'h0000DEAD_00001234);

    // Held OpValid: MADD then MTLO on the same lines (split instance only)
    issue(3'd1, 64'h00000002_80000000, 32'd0, 1'b1, 64'h00000002_80000000);
    en0 = 1'b0;
    @(negedge Clk);
    OpValid = 1'b1; OpCode = 3'd2; Product = 64'h00000000_80000000;
    q1.push_back(64'h00000003_00000000);
    @(negedge Clk);
    OpCode = 3'd5; WrData = 32'h00000055; Product = 64'hDEADBEEF_DEADBEEF;
    q1.push_back(64'h00000003_00000055);
    @(negedge Clk);
    chk("held k+1 hilo", {Hi, Lo}, 64'h00000002_00000000);
    chk("held k+1 ready", {63'd0, OpReady}, 64'd0);
    @(negedge Clk);
    chk("held k+2 lo", {32'd0, Lo}, 64'd0);
    @(negedge Clk);
    OpValid = 1'b0;
    chk("held k+3 hilo", {Hi, Lo}, 64'h00000003_00000055);

    // Reset during ACC_HI aborts with no Done
    en0 = 1'b1;
    issue(3'd1, 64'h00000004_00000004, 32'd0, 1'b1, 64'h00000004_00000004);
    en0 = 1'b0;
    issue(3'd2, 64'd1, 32'd0, 1'b0, 64'd0);
    @(negedge Clk);
    chk("abort acc_hi lo", {Hi, Lo}, 64'h00000004_00000005);
    Reset = 1'b1;
    #1;
    chk("abort hilo", {Hi, Lo}, 64'd0);
    chk("abort busy/ready/done", {61'd0, Busy, OpReady, Done}, 64'b010);
    @(negedge Clk);
    Reset = 1'b0;
    en0 = 1'b1;
    repeat (3) begin
      @(negedge Clk);
      chk("abort no_done", {63'd0, Done}, 64'd0);
    end
    issue(3'd1, 64'h0000ABCD_00001234, 32'd0, 1'b1, 64'h0000ABCD_00001234);

    repeat (4) @(negedge Clk);
    chk("split queue drained", 64'(q1.size()), 64'd0);
    chk("single queue drained", 64'(q0.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running expected finished");
    $fatal(1);
  end

endmodule
